// File: rtl/hazard_pkg.sv
// Shared types and constants for the sequenced hazard controller.
package hazard_pkg;

  // Opcodes with a hazard effect; all others decode as "no hazard".
  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_BGT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Width of the stall/flush down-counter (holds up to 3 remaining cycles).
  localparam int unsigned CNT_W = 2;

  // Comparator result for the instruction in ID.
  typedef enum logic [1:0] {
    CMP_LT   = 2'b00,
    CMP_GT   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_NONE = 2'b11
  } cmp_e;

  // PC source select.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  // Controller state.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  // Control bundle driven towards PC/IF and ID/EX.
  typedef struct packed {
    logic       pc_write;
    logic       if_write;
    logic       id_bubble;
    logic       flush_if;
    logic [1:0] pc_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_write: 1'b1, id_bubble: 1'b0,
                                 flush_if: 1'b0, pc_sel: PC_SEQ};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: clear wins, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Sequenced hazard controller: load-use stalls, redirect flush windows,
// sticky halt with resume, and saturating stall/redirect counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned OP_WIDTH     = 4,
  parameter int unsigned REG_WIDTH    = 4,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_DEPTH  = 1,
  parameter bit          R0_HARDWIRED = 1'b1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_WIDTH-1:0]  opcode_id,
  input  logic [REG_WIDTH-1:0] rs_id,
  input  logic [REG_WIDTH-1:0] rt_id,
  input  logic [REG_WIDTH-1:0] rd_ex,
  input  logic                 mem_read_ex,
  input  logic [1:0]           cmp_flags,
  input  logic                 resume,
  input  logic                 cnt_clr,
  output logic                 pc_write,
  output logic                 if_write,
  output logic                 id_bubble,
  output logic                 flush_if,
  output logic [1:0]           pc_sel,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             redirect;
  logic             load_use;
  logic             br_taken;
  logic             is_jump;
  logic             is_halt;
  logic             stall_inc;

  // Hazard decode for the instruction currently in ID.
  always_comb begin
    load_use = mem_read_ex && ((rd_ex == rs_id) || (rd_ex == rt_id))
               && !(R0_HARDWIRED && (rd_ex == '0));
    br_taken = ((opcode_id == OP_WIDTH'(OP_BLT)) && (cmp_flags == CMP_LT))
            || ((opcode_id == OP_WIDTH'(OP_BGT)) && (cmp_flags == CMP_GT))
            || ((opcode_id == OP_WIDTH'(OP_BEQ)) && (cmp_flags == CMP_EQ));
    is_jump  = (opcode_id == OP_WIDTH'(OP_JMP));
    is_halt  = (opcode_id == OP_WIDTH'(OP_HALT));
  end

  // Next-state and Mealy control outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = CTRL_RUN;
    redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          ctrl.pc_write  = 1'b0;
          ctrl.if_write  = 1'b0;
          ctrl.id_bubble = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_d = ST_STALL;
            cnt_d   = CNT_W'(LOAD_LATENCY - 1);
          end
        end else if (br_taken || is_jump) begin
          ctrl.flush_if = 1'b1;
          ctrl.pc_sel   = br_taken ? PC_BRANCH : PC_JUMP;
          redirect      = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
          end
        end else if (is_halt) begin
          ctrl.pc_write = 1'b0;
          ctrl.if_write = 1'b0;
          state_d       = ST_HALTED;
        end
      end
      ST_STALL: begin
        // Everything but the countdown is ignored while the load completes.
        ctrl.pc_write  = 1'b0;
        ctrl.if_write  = 1'b0;
        ctrl.id_bubble = 1'b1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Wrong-path fetches keep being squashed; no new decode.
        ctrl.flush_if = 1'b1;
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        ctrl.pc_write  = 1'b0;
        ctrl.if_write  = 1'b0;
        ctrl.id_bubble = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State and down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write  = ctrl.pc_write;
  assign if_write  = ctrl.if_write;
  assign id_bubble = ctrl.id_bubble;
  assign flush_if  = ctrl.flush_if;
  assign pc_sel    = ctrl.pc_sel;
  assign halted    = (state_q == ST_HALTED);

  // Bubbles inserted while halted are not stalls.
  assign stall_inc = ctrl.id_bubble && (state_q != ST_HALTED);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (stall_inc),
    .clr     (cnt_clr),
    .count_o (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (redirect),
    .clr     (cnt_clr),
    .count_o (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two controllers share stimulus, one with long stall/flush
// and 4-bit counters, one with single-cycle stall/flush and 16-bit counters.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode_id;
  logic [3:0] rs_id, rt_id, rd_ex;
  logic       mem_read_ex;
  logic [1:0] cmp_flags;
  logic       resume;
  logic       cnt_clr;

  logic        a_pc_write, a_if_write, a_id_bubble, a_flush_if, a_halted;
  logic [1:0]  a_pc_sel;
  logic [3:0]  a_stall, a_flush;
  logic        b_pc_write, b_if_write, b_id_bubble, b_flush_if, b_halted;
  logic [1:0]  b_pc_sel;
  logic [15:0] b_stall, b_flush;
  logic [5:0]  a_ctrl, b_ctrl;

  int total = 0;
  int bad   = 0;

  assign a_ctrl = {a_pc_write, a_if_write, a_id_bubble, a_flush_if, a_pc_sel};
  assign b_ctrl = {b_pc_write, b_if_write, b_id_bubble, b_flush_if, b_pc_sel};

  hazard_ctrl #(.OP_WIDTH(4), .REG_WIDTH(4), .LOAD_LATENCY(3), .FLUSH_DEPTH(2),
                .R0_HARDWIRED(1'b1), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .cmp_flags(cmp_flags), .resume(resume),
    .cnt_clr(cnt_clr), .pc_write(a_pc_write), .if_write(a_if_write),
    .id_bubble(a_id_bubble), .flush_if(a_flush_if), .pc_sel(a_pc_sel),
    .halted(a_halted), .stall_cycles(a_stall), .flush_events(a_flush)
  );

  hazard_ctrl #(.OP_WIDTH(4), .REG_WIDTH(4), .LOAD_LATENCY(1), .FLUSH_DEPTH(1),
                .R0_HARDWIRED(1'b1), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .cmp_flags(cmp_flags), .resume(resume),
    .cnt_clr(cnt_clr), .pc_write(b_pc_write), .if_write(b_if_write),
    .id_bubble(b_id_bubble), .flush_if(b_flush_if), .pc_sel(b_pc_sel),
    .halted(b_halted), .stall_cycles(b_stall), .flush_events(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vectors {pc_write, if_write, id_bubble, flush_if, pc_sel}
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_BR    = 6'b110101;
  localparam logic [5:0] C_JMP   = 6'b110110;
  localparam logic [5:0] C_FLUSH = 6'b110100;
  localparam logic [5:0] C_HALT  = 6'b000000;

  task automatic idle_inputs();
    opcode_id = 4'h0; rs_id = 4'h0; rt_id = 4'h0; rd_ex = 4'h0;
    mem_read_ex = 1'b0; cmp_flags = 2'b11; resume = 1'b0; cnt_clr = 1'b0;
  endtask

  // Pulse reset and return at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL rst_ctrl: got %b want %b", a_ctrl, C_RUN); end
    total++; if (a_halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", a_halted); end
    total++; if ({a_stall, a_flush} !== 8'h00) begin bad++; $display("FAIL rst_cnt: got %h want 00", {a_stall, a_flush}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL rst_quiet: got %b want %b", a_ctrl, C_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 4'd5; rs_id = 4'd5; rt_id = 4'd2;
    #1;
    total++; if (a_ctrl !== C_STALL) begin bad++; $display("FAIL lu_a_c0: got %b want %b", a_ctrl, C_STALL); end
    total++; if (b_ctrl !== C_STALL) begin bad++; $display("FAIL lu_b_c0: got %b want %b", b_ctrl, C_STALL); end
    @(negedge clk);
    mem_read_ex = 1'b0;
    #1;
    total++; if (a_ctrl !== C_STALL) begin bad++; $display("FAIL lu_a_c1: got %b want %b", a_ctrl, C_STALL); end
    total++; if (b_ctrl !== C_RUN) begin bad++; $display("FAIL lu_b_c1: got %b want %b", b_ctrl, C_RUN); end
    @(negedge clk); #1;
    total++; if (a_ctrl !== C_STALL) begin bad++; $display("FAIL lu_a_c2: got %b want %b", a_ctrl, C_STALL); end
    @(negedge clk); #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL lu_a_c3: got %b want %b", a_ctrl, C_RUN); end
    total++; if (a_stall !== 4'd3) begin bad++; $display("FAIL lu_a_stallcnt: got %0d want 3", a_stall); end
    total++; if (b_stall !== 16'd1) begin bad++; $display("FAIL lu_b_stallcnt: got %0d want 1", b_stall); end
  endtask

  task automatic test_r0();
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 4'd0; rt_id = 4'd0; rs_id = 4'd3;
    #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL r0_a: got %b want %b", a_ctrl, C_RUN); end
    total++; if (b_ctrl !== C_RUN) begin bad++; $display("FAIL r0_b: got %b want %b", b_ctrl, C_RUN); end
    @(negedge clk);
    rd_ex = 4'd7; rt_id = 4'd7;
    #1;
    total++; if (a_ctrl !== C_STALL) begin bad++; $display("FAIL r7_rt: got %b want %b", a_ctrl, C_STALL); end
  endtask

  task automatic test_branch();
    do_reset();
    opcode_id = 4'b0110; cmp_flags = 2'b10;
    #1;
    total++; if (a_ctrl !== C_BR) begin bad++; $display("FAIL beq_a_c0: got %b want %b", a_ctrl, C_BR); end
    total++; if (b_ctrl !== C_BR) begin bad++; $display("FAIL beq_b_c0: got %b want %b", b_ctrl, C_BR); end
    @(negedge clk);
    opcode_id = 4'h0; cmp_flags = 2'b11;
    #1;
    total++; if (a_ctrl !== C_FLUSH) begin bad++; $display("FAIL beq_a_c1: got %b want %b", a_ctrl, C_FLUSH); end
    total++; if (b_ctrl !== C_RUN) begin bad++; $display("FAIL beq_b_c1: got %b want %b", b_ctrl, C_RUN); end
    @(negedge clk); #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL beq_a_c2: got %b want %b", a_ctrl, C_RUN); end
    total++; if (a_flush !== 4'd1) begin bad++; $display("FAIL beq_a_events: got %0d want 1", a_flush); end
    opcode_id = 4'b0110; cmp_flags = 2'b00;
    #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL beq_nt: got %b want %b", a_ctrl, C_RUN); end
    opcode_id = 4'b0100; cmp_flags = 2'b01;
    #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL blt_nt: got %b want %b", a_ctrl, C_RUN); end
    opcode_id = 4'b0101; cmp_flags = 2'b01;
    #1;
    total++; if (a_ctrl !== C_BR) begin bad++; $display("FAIL bgt_t: got %b want %b", a_ctrl, C_BR); end
    @(negedge clk);
    opcode_id = 4'b1100; cmp_flags = 2'b11;
    #1;
    total++; if (a_ctrl !== C_FLUSH) begin bad++; $display("FAIL jmp_a_in_flush: got %b want %b", a_ctrl, C_FLUSH); end
    total++; if (b_ctrl !== C_JMP) begin bad++; $display("FAIL jmp_b: got %b want %b", b_ctrl, C_JMP); end
    @(negedge clk);
    opcode_id = 4'h0;
    #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL jmp_a_after: got %b want %b", a_ctrl, C_RUN); end
    total++; if (a_flush !== 4'd2) begin bad++; $display("FAIL br_a_events: got %0d want 2", a_flush); end
    total++; if (b_flush !== 16'd3) begin bad++; $display("FAIL br_b_events: got %0d want 3", b_flush); end
  endtask

  task automatic test_concurrent();
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 4'd4; rs_id = 4'd4; opcode_id = 4'b0100; cmp_flags = 2'b00;
    #1;
    total++; if (b_ctrl !== C_STALL) begin bad++; $display("FAIL cc_b_c0: got %b want %b", b_ctrl, C_STALL); end
    @(negedge clk);
    mem_read_ex = 1'b0;
    #1;
    total++; if (b_ctrl !== C_BR) begin bad++; $display("FAIL cc_b_c1: got %b want %b", b_ctrl, C_BR); end
    total++; if (a_ctrl !== C_STALL) begin bad++; $display("FAIL cc_a_c1: got %b want %b", a_ctrl, C_STALL); end
    @(negedge clk);
    opcode_id = 4'h0; cmp_flags = 2'b11;
    #1;
    total++; if (b_ctrl !== C_RUN) begin bad++; $display("FAIL cc_b_c2: got %b want %b", b_ctrl, C_RUN); end
    @(negedge clk); #1;
    total++; if ({a_flush, b_flush} !== 20'h00001) begin bad++; $display("FAIL cc_events: got %h want 00001", {a_flush, b_flush}); end
  endtask

  task automatic test_halt();
    do_reset();
    opcode_id = 4'b1111;
    #1;
    total++; if (a_ctrl !== C_HALT) begin bad++; $display("FAIL halt_detect: got %b want %b", a_ctrl, C_HALT); end
    total++; if (a_halted !== 1'b0) begin bad++; $display("FAIL halt_detect_flag: got %b want 0", a_halted); end
    @(negedge clk);
    opcode_id = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({a_halted, a_ctrl} !== {1'b1, C_STALL}) begin
        bad++; $display("FAIL halt_hold%0d: got %b want %b", i, {a_halted, a_ctrl}, {1'b1, C_STALL});
      end
      @(negedge clk);
    end
    resume = 1'b1;
    #1;
    total++; if (b_halted !== 1'b1) begin bad++; $display("FAIL halt_b_before_resume: got %b want 1", b_halted); end
    @(negedge clk);
    resume = 1'b0;
    #1;
    total++; if ({a_halted, a_ctrl} !== {1'b0, C_RUN}) begin bad++; $display("FAIL resume: got %b want %b", {a_halted, a_ctrl}, {1'b0, C_RUN}); end
    total++; if (a_stall !== 4'd0) begin bad++; $display("FAIL halt_nostall: got %0d want 0", a_stall); end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    total++; if ({a_halted, a_ctrl} !== {1'b0, C_RUN}) begin bad++; $display("FAIL resume_in_run: got %b want %b", {a_halted, a_ctrl}, {1'b0, C_RUN}); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    opcode_id = 4'b1111;
    @(negedge clk);
    opcode_id = 4'h0;
    #1;
    total++; if (a_halted !== 1'b1) begin bad++; $display("FAIL abort_pre_halt: got %b want 1", a_halted); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({a_halted, a_ctrl} !== {1'b0, C_RUN}) begin bad++; $display("FAIL abort_halt: got %b want %b", {a_halted, a_ctrl}, {1'b0, C_RUN}); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_read_ex = 1'b1; rd_ex = 4'd5; rs_id = 4'd5;
    @(negedge clk);
    mem_read_ex = 1'b0;
    #1;
    total++; if (a_ctrl !== C_STALL) begin bad++; $display("FAIL abort_pre_stall: got %b want %b", a_ctrl, C_STALL); end
    rst_n = 1'b0;
    #1;
    total++; if ({a_ctrl, a_stall} !== {C_RUN, 4'd0}) begin bad++; $display("FAIL abort_stall: got %b want %b", {a_ctrl, a_stall}, {C_RUN, 4'd0}); end
    @(negedge clk);
    rst_n = 1'b1;
    opcode_id = 4'b0110; cmp_flags = 2'b10;
    @(negedge clk);
    opcode_id = 4'h0; cmp_flags = 2'b11;
    #1;
    total++; if (a_ctrl !== C_FLUSH) begin bad++; $display("FAIL abort_pre_flush: got %b want %b", a_ctrl, C_FLUSH); end
    rst_n = 1'b0;
    #1;
    total++; if (a_ctrl !== C_RUN) begin bad++; $display("FAIL abort_flush: got %b want %b", a_ctrl, C_RUN); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 4'd5; rs_id = 4'd5;
    repeat (20) @(negedge clk);
    #1;
    total++; if (a_stall !== 4'd15) begin bad++; $display("FAIL sat_a: got %0d want 15", a_stall); end
    total++; if (b_stall !== 16'd20) begin bad++; $display("FAIL sat_b: got %0d want 20", b_stall); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    total++; if ({a_stall, b_stall} !== 20'h00000) begin bad++; $display("FAIL clr_prio: got %h want 00000", {a_stall, b_stall}); end
    @(negedge clk);
    mem_read_ex = 1'b0;
    #1;
    total++; if ({a_stall, b_stall} !== 20'h10001) begin bad++; $display("FAIL clr_resume_count: got %h want 10001", {a_stall, b_stall}); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_r0();
    test_branch();
    test_concurrent();
    test_halt();
    test_reset_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
